// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the operand-fetch stage.
//   CTRL_W    : width of the control bundle carried from ID to EX
//   REG_PC    : register number aliased to the PC; never forwarded
//   state_t   : operand-fetch FSM state (RUN / HOLD)
//   src_match : true when a producer writes the register a source reads
package pipe_pkg;

   localparam int unsigned CTRL_W = 16;
   localparam logic [3:0]  REG_PC = 4'hF;

   typedef logic [0:0] state_t;
   localparam state_t RUN  = 1'b0;
   localparam state_t HOLD = 1'b1;

   function automatic logic src_match(input logic       use_src,
                                      input logic       valid,
                                      input logic [3:0] src,
                                      input logic       we,
                                      input logic [3:0] rd);
      return use_src && valid && (src != REG_PC) && we && (rd == src);
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority forward select for one 32-bit source operand.
// Ports:
//   src, use_src, valid : source register, used flag, ID slot valid
//   rf_val              : register-file read value (fallback)
//   ex_*                : EX producer; ex_fwd_ok is low for loads
//   mem_*, wb_*         : MEM and WB producers
//   fwd_val             : selected operand
module fwd_mux
   import pipe_pkg::*;
(
   input  logic [3:0]  src,
   input  logic        use_src,
   input  logic        valid,
   input  logic [31:0] rf_val,
   input  logic [3:0]  ex_rd,
   input  logic        ex_rf_we,
   input  logic        ex_fwd_ok,
   input  logic [31:0] ex_result,
   input  logic [3:0]  mem_rd,
   input  logic        mem_rf_we,
   input  logic [31:0] mem_result,
   input  logic [3:0]  wb_rd,
   input  logic        wb_rf_we,
   input  logic [31:0] wb_data,
   output logic [31:0] fwd_val
);

   logic hit_ex, hit_mem, hit_wb;

   assign hit_ex  = ex_fwd_ok && src_match(use_src, valid, src, ex_rf_we, ex_rd);
   assign hit_mem = src_match(use_src, valid, src, mem_rf_we, mem_rd);
   assign hit_wb  = src_match(use_src, valid, src, wb_rf_we, wb_rd);

   always_comb begin
      fwd_val = rf_val;
      if (hit_ex) begin
         fwd_val = ex_result;
      end else if (hit_mem) begin
         fwd_val = mem_result;
      end else if (hit_wb) begin
         fwd_val = wb_data;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch with EX/MEM/WB forwarding, one-cycle load-use stall and ID/EX register.
// Ports:
//   clock, R            : clock and synchronous active-low reset
//   id_*                : decoded instruction in the ID slot
//   pa, pb, pc          : register-file read data
//   ex_*/mem_*/wb_*     : downstream producers for forwarding
//   flush               : kill the ID slot (taken branch)
//   stall               : hold PC and IF/ID this cycle
//   ex_valid .. ex_ctrl_o : ID/EX pipeline register
//   stall_cnt           : saturating load-use stall counter
module operand_fetch
   import pipe_pkg::*;
(
   input  logic              clock,
   input  logic              R,
   input  logic              id_valid,
   input  logic [3:0]        id_ra,
   input  logic [3:0]        id_rb,
   input  logic [3:0]        id_rc,
   input  logic              id_use_a,
   input  logic              id_use_b,
   input  logic              id_use_c,
   input  logic [31:0]       pa,
   input  logic [31:0]       pb,
   input  logic [31:0]       pc,
   input  logic [3:0]        id_rd,
   input  logic              id_rf_we,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [3:0]        ex_rd,
   input  logic              ex_rf_we,
   input  logic              ex_is_load,
   input  logic [31:0]       ex_result,
   input  logic [3:0]        mem_rd,
   input  logic              mem_rf_we,
   input  logic [31:0]       mem_result,
   input  logic [3:0]        wb_rd,
   input  logic              wb_rf_we,
   input  logic [31:0]       wb_data,
   input  logic              flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [31:0]       ex_opa,
   output logic [31:0]       ex_opb,
   output logic [31:0]       ex_opc,
   output logic [3:0]        ex_rd_o,
   output logic              ex_rf_we_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic [15:0]       stall_cnt
);

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic [31:0]       opa_q, opa_d, opb_q, opb_d, opc_q, opc_d;
   logic [3:0]        rd_q, rd_d;
   logic              we_q, we_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [31:0]       fwd_a, fwd_b, fwd_c;
   logic              hazard;

   fwd_mux u_fwd_a (
      .src(id_ra), .use_src(id_use_a), .valid(id_valid), .rf_val(pa),
      .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_fwd_ok(!ex_is_load), .ex_result(ex_result),
      .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data), .fwd_val(fwd_a)
   );

   fwd_mux u_fwd_b (
      .src(id_rb), .use_src(id_use_b), .valid(id_valid), .rf_val(pb),
      .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_fwd_ok(!ex_is_load), .ex_result(ex_result),
      .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data), .fwd_val(fwd_b)
   );

   fwd_mux u_fwd_c (
      .src(id_rc), .use_src(id_use_c), .valid(id_valid), .rf_val(pc),
      .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_fwd_ok(!ex_is_load), .ex_result(ex_result),
      .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data), .fwd_val(fwd_c)
   );

   // Load data is not ready in EX; only checked in RUN so a stall never lasts two cycles.
   assign hazard = (state_q == RUN) && ex_is_load &&
                   (src_match(id_use_a, id_valid, id_ra, ex_rf_we, ex_rd) ||
                    src_match(id_use_b, id_valid, id_rb, ex_rf_we, ex_rd) ||
                    src_match(id_use_c, id_valid, id_rc, ex_rf_we, ex_rd));

   // Gated by R so stall is quiet throughout reset.
   assign stall = R && hazard && !flush;

   always_comb begin
      state_d = RUN;
      valid_d = 1'b0;
      opa_d   = '0;
      opb_d   = '0;
      opc_d   = '0;
      rd_d    = '0;
      we_d    = 1'b0;
      ctrl_d  = '0;
      cnt_d   = cnt_q;
      if (stall) begin
         state_d = HOLD;
         if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
         end
      end else if (!flush && id_valid) begin
         valid_d = 1'b1;
         opa_d   = fwd_a;
         opb_d   = fwd_b;
         opc_d   = fwd_c;
         rd_d    = id_rd;
         we_d    = id_rf_we;
         ctrl_d  = id_ctrl;
      end
   end

   always_ff @(posedge clock) begin
      if (!R) begin
         state_q <= RUN;
         valid_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         opc_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         opc_q   <= opc_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid   = valid_q;
   assign ex_opa     = opa_q;
   assign ex_opb     = opb_q;
   assign ex_opc     = opc_q;
   assign ex_rd_o    = rd_q;
   assign ex_rf_we_o = we_q;
   assign ex_ctrl_o  = ctrl_q;
   assign stall_cnt  = cnt_q;

endmodule
